// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the memory-mapped IO responder.
// Holds the register offsets (CPU addr[3:2]) used by the memory decoder and
// tests, the STATUS/LED bit positions, and the button debouncer state type.
package io_port_responder_pkg;

    localparam logic [1:0] IO_STATUS = 2'd0;
    localparam logic [1:0] IO_OPA    = 2'd1;
    localparam logic [1:0] IO_OPB    = 2'd2;
    localparam logic [1:0] IO_LED    = 2'd3;

    localparam int unsigned STATUS_LEDRDY_BIT = 0;
    localparam int unsigned STATUS_SWRDY_BIT  = 1;
    localparam int unsigned LED_SIGN_BIT      = 12;
    localparam int unsigned LED_WIDTH         = 12;

    typedef enum logic [1:0] {
        STABLE_LO,
        CNT_HI,
        STABLE_HI,
        CNT_LO
    } deb_state_t;

endpackage

// File: rtl/io_port_responder_btn_debounce.sv
// Button conditioner: SYNC_STAGES-deep synchronizer, debounce FSM, and a
// one-cycle pulse on each accepted press (low-to-high qualified transition).
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   btn    in  raw asynchronous button
//   press  out one-cycle pulse when a press has been stable DEBOUNCE_CYCLES
module io_port_responder_btn_debounce
    import io_port_responder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The press pulse is emitted on the qualifying CNT_HI -> STABLE_HI step,
    // so a held button can never produce a second pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync_out) begin
                    state_d = CNT_HI;
                    cnt_d   = '0;
                end
            end
            CNT_HI: begin
                if (!sync_out) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_out) begin
                    state_d = CNT_LO;
                    cnt_d   = '0;
                end
            end
            CNT_LO: begin
                if (sync_out) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral-side responder for the memory-mapped IO window.
// Debounces btnL/btnR into handshake flags, snapshots the switches on a
// btnR press, exposes STATUS/OPA/OPB to the CPU and latches LED/sign writes.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   pRead, pWrite       CPU read/write strobes for the IO window
//   addr                register select (CPU addr[3:2])
//   writeData/readData  CPU data; readData combinational, 0 when pRead=0
//   btnL, btnR          raw buttons (LED port ready / operands valid)
//   switch              raw switch inputs
//   led, sign           latched result magnitude and sign for display
module io_port_responder
    import io_port_responder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pRead,
    input  logic                 pWrite,
    input  logic [1:0]           addr,
    input  logic [31:0]          writeData,
    output logic [31:0]          readData,
    input  logic                 btnL,
    input  logic                 btnR,
    input  logic [15:0]          switch,
    output logic [LED_WIDTH-1:0] led,
    output logic                 sign
);

    logic        press_l, press_r;
    logic        led_rdy, sw_rdy;
    logic [15:0] sw_snap;
    logic [15:0] sw_sync [SYNC_STAGES];
    logic        led_wr, opb_rd;
    logic        unused_wd;

    assign unused_wd = ^writeData[31:LED_SIGN_BIT+1];

    io_port_responder_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb_l (
        .clk  (clk),
        .reset(reset),
        .btn  (btnL),
        .press(press_l)
    );

    io_port_responder_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb_r (
        .clk  (clk),
        .reset(reset),
        .btn  (btnR),
        .press(press_r)
    );

    assign led_wr = pWrite && (addr == IO_LED);
    assign opb_rd = pRead && (addr == IO_OPB);

    // Switches share the button synchronizer depth so the snapshot is
    // taken from the same clock-domain view as the press that triggers it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
        end else begin
            sw_sync[0] <= switch;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    // Set beats clear on both handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            sign    <= 1'b0;
            led_rdy <= 1'b0;
            sw_rdy  <= 1'b0;
            sw_snap <= '0;
        end else begin
            if (led_wr) begin
                led  <= writeData[LED_WIDTH-1:0];
                sign <= writeData[LED_SIGN_BIT];
            end
            if (press_l)     led_rdy <= 1'b1;
            else if (led_wr) led_rdy <= 1'b0;
            if (press_r) begin
                sw_rdy  <= 1'b1;
                sw_snap <= sw_sync[SYNC_STAGES-1];
            end else if (opb_rd) begin
                sw_rdy <= 1'b0;
            end
        end
    end

    always_comb begin
        readData = '0;
        if (pRead) begin
            case (addr)
                IO_STATUS: begin
                    readData[STATUS_LEDRDY_BIT] = led_rdy;
                    readData[STATUS_SWRDY_BIT]  = sw_rdy;
                end
                IO_OPA:  readData[7:0] = sw_snap[15:8];
                IO_OPB:  readData[7:0] = sw_snap[7:0];
                default: readData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Randomized and directed bench for io_port_responder with a run-length
// reference model of button qualification and a register-level model.
module tb_io_port_responder;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pRead, pWrite;
    logic [1:0]  addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        btnL, btnR;
    logic [15:0] switch;
    logic [11:0] led;
    logic        sign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_port_responder #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pRead    (pRead),
        .pWrite   (pWrite),
        .addr     (addr),
        .writeData(writeData),
        .readData (readData),
        .btnL     (btnL),
        .btnR     (btnR),
        .switch   (switch),
        .led      (led),
        .sign     (sign)
    );

    // Reference model: buttons/switches seen S cycles late; a level change
    // is accepted once the delayed input has differed from the accepted
    // level for D+1 consecutive samples (entry sample plus D counted ones).
    bit          m_qL [S];
    bit          m_qR [S];
    bit   [15:0] m_qSw [S];
    bit          m_lvlL, m_lvlR;
    int          m_runL, m_runR;
    bit   [11:0] m_led;
    bit          m_sign, m_ledRdy, m_swRdy;
    bit   [15:0] m_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_qL[i] = 0; m_qR[i] = 0; m_qSw[i] = 0;
        end
        m_lvlL = 0; m_lvlR = 0; m_runL = 0; m_runR = 0;
        m_led = 0; m_sign = 0; m_ledRdy = 0; m_swRdy = 0; m_snap = 0;
    endtask

    task automatic qualify(input bit in, inout bit lvl, inout int run, output bit p);
        p = 0;
        if (in != lvl) begin
            run++;
            if (run == D + 1) begin
                lvl = in;
                run = 0;
                p   = in;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge();
        bit pL, pR, wr, rdB;
        qualify(m_qL[S-1], m_lvlL, m_runL, pL);
        qualify(m_qR[S-1], m_lvlR, m_runR, pR);
        wr  = pWrite && (addr == 2'd3);
        rdB = pRead && (addr == 2'd2);
        if (wr) begin
            m_led  = writeData[11:0];
            m_sign = writeData[12];
        end
        if (pL) m_ledRdy = 1;
        else if (wr) m_ledRdy = 0;
        if (pR) begin
            m_swRdy = 1;
            m_snap  = m_qSw[S-1];
        end else if (rdB) begin
            m_swRdy = 0;
        end
        for (int i = S - 1; i > 0; i--) begin
            m_qL[i] = m_qL[i-1]; m_qR[i] = m_qR[i-1]; m_qSw[i] = m_qSw[i-1];
        end
        m_qL[0] = btnL; m_qR[0] = btnR; m_qSw[0] = switch;
    endtask

    function automatic logic [31:0] exp_rd();
        if (!pRead) return 32'h0;
        case (addr)
            2'd0:    return {30'h0, m_swRdy, m_ledRdy};
            2'd1:    return {24'h0, m_snap[15:8]};
            2'd2:    return {24'h0, m_snap[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Called just after a falling edge with inputs set; returns at the next
    // falling edge after modelling the intervening rising edge.
    task automatic tick();
        #1;
        check("readData", readData, exp_rd());
        check("led", {20'h0, led}, {20'h0, m_led});
        check("sign", {31'h0, sign}, {31'h0, m_sign});
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pRead = 0; pWrite = 0; addr = 0; writeData = 0;
    endtask

    task automatic run_idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic random_phase(input int n);
        int hL, hR, rst_hold;
        hL = 0; hR = 0; rst_hold = 0;
        for (int c = 0; c < n; c++) begin
            if (hL == 0) begin btnL = 1'($urandom_range(0, 1)); hL = $urandom_range(1, 12); end
            else hL--;
            if (hR == 0) begin btnR = 1'($urandom_range(0, 1)); hR = $urandom_range(1, 12); end
            else hR--;
            if ($urandom_range(0, 7) == 0) switch = 16'($urandom);
            pRead     = 1'($urandom_range(0, 1));
            pWrite    = ($urandom_range(0, 3) == 0);
            addr      = 2'($urandom_range(0, 3));
            writeData = $urandom;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                model_reset();
                rst_hold = $urandom_range(1, 3);
            end
            tick();
        end
        reset = 1;
    endtask

    task automatic press_r_full(input logic [15:0] sw);
        switch = sw;
        run_idle(4);
        btnR = 1;
        run_idle(20);
        btnR = 0;
        run_idle(12);
    endtask

    initial begin
        reset = 0; btnL = 0; btnR = 0; switch = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        tick();
        reset = 1;

        random_phase(200);

        // 1: reset mid-run, possibly mid-debounce
        btnL = 1; btnR = 1;
        run_idle(S + 2);
        reset = 0;
        model_reset();
        pRead = 1;
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1 check("t1_read_in_reset", readData, 32'h0);
        end
        check("t1_led", {20'h0, led}, 32'h0);
        check("t1_sign", {31'h0, sign}, 32'h0);
        btnL = 0; btnR = 0;
        run_idle(3);
        reset = 1;
        run_idle(S + D + 4);

        // 2: single press captures A53C
        press_r_full(16'hA53C);
        pRead = 1; addr = 0;
        #1 check("t2_status", readData, 32'h2);
        tick();
        pRead = 1; addr = 1;
        #1 check("t2_opa", readData, 32'hA5);
        tick();
        pRead = 1; addr = 2;
        #1 check("t2_opb", readData, 32'h3C);
        tick();
        pRead = 1; addr = 0;
        #1 check("t2_status_cleared", readData, 32'h0);
        tick();

        // 3: bounce shorter than qualification produces nothing
        for (int k = 0; k < 8; k++) begin
            btnR = (k % 4) < 2;
            tick();
        end
        btnR = 0;
        run_idle(12);
        pRead = 1; addr = 0;
        #1 check("t3_status", readData, 32'h0);
        tick();

        // 4: LED write after a btnL press
        switch = 16'h0;
        btnL = 1;
        run_idle(20);
        btnL = 0;
        run_idle(12);
        pRead = 1; addr = 0;
        #1 check("t4_ledrdy_set", readData, 32'h1);
        pRead = 0; pWrite = 1; addr = 3; writeData = 32'h0000_1ABC;
        tick();
        idle_inputs();
        #1 check("t4_led", {20'h0, led}, 32'hABC);
        check("t4_sign", {31'h0, sign}, 32'h1);
        pRead = 1; addr = 0;
        #1 check("t4_ledrdy_clr", readData, 32'h0);
        tick();

        // 5: press completes on the same edge as a clearing OPB read
        press_r_full(16'h1111);
        switch = 16'h22CC;
        run_idle(4);
        btnR = 1;
        for (int k = 1; k <= S + D + 1; k++) begin
            pRead = (k == S + D + 1);
            addr  = 2;
            tick();
        end
        pRead = 1; addr = 0;
        #1 check("t5_status", readData, 32'h2);
        tick();
        pRead = 1; addr = 2;
        #1 check("t5_opb", readData, 32'hCC);
        tick();
        btnR = 0;
        run_idle(12);

        // 6: btnL held through reset release is re-qualified once
        btnL = 1;
        run_idle(10);
        reset = 0;
        model_reset();
        run_idle(3);
        reset = 1;
        for (int k = 0; k <= S + D + 6; k++) begin
            pRead = 1; addr = 0;
            #1 check("t6_ledrdy", {31'h0, readData[0]}, {31'h0, (k > S + D)});
            tick();
        end
        btnL = 0;
        run_idle(12);

        random_phase(2500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench exceeded its time limit");
        $fatal(1);
    end

endmodule
